// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared constants and dump-state encoding for the data memory.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;
    localparam int N      = 64;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;
endpackage
`default_nettype wire

// File: rtl/dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dump_sequencer
// Brief   : Edge-triggered dump FSM streaming memory words over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module dump_sequencer #(
    parameter int N      = dmem_pkg::N,
    parameter int ADDR_W = dmem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dump,
    input  logic              i_dump_ready,
    input  logic [N-1:0]      i_rd_data,
    output logic [ADDR_W-1:0] o_rd_idx,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_index,
    output logic [N-1:0]      o_dump_data,
    output logic              o_dump_busy,
    output logic              o_dump_done
);
    import dmem_pkg::*;

    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last = '1;

    dump_state_t       r_state;
    logic              r_dump_q;
    logic [ADDR_W-1:0] r_index;
    logic [N-1:0]      r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    // Index of the word to be latched at the next edge (first beat or successor).
    assign o_rd_idx = (r_state == IDLE) ? '0 : r_index + c_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dump_q <= 1'b0;
            r_index  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_dump_q <= i_dump;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_dump && !r_dump_q) begin
                        r_index <= '0;
                        r_data  <= i_rd_data;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (r_valid && i_dump_ready) begin
                        if (r_index == c_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_index <= r_index + c_one;
                            r_data  <= i_rd_data;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_dump_valid = r_valid;
    assign o_dump_index = r_index;
    assign o_dump_data  = r_data;
    assign o_dump_busy  = r_busy;
    assign o_dump_done  = r_done;
endmodule
`default_nettype wire

// File: rtl/data_mem_dump.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_dump
// Brief   : Word-addressed data memory with combinational read and dump engine.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_dump #(
    parameter int N      = dmem_pkg::N,
    parameter int ADDR_W = dmem_pkg::ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N-1:0]      DM_addr,
    input  logic [N-1:0]      DM_writeData,
    input  logic              DM_writeEnable,
    input  logic              DM_readEnable,
    output logic [N-1:0]      DM_readData,
    input  logic              dump,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [N-1:0]      dump_data,
    output logic              dump_busy,
    output logic              dump_done
);
    import dmem_pkg::*;

    localparam int c_depth = 1 << ADDR_W;

    logic [N-1:0]      r_mem [0:c_depth-1];
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_seq_rd_idx;
    logic [N-1:0]      w_seq_rd_data;
    logic              w_addr_unused;

    // Byte offset and bits above the word index are dropped, so addresses wrap.
    assign w_idx         = DM_addr[ADDR_W+2:3];
    assign w_addr_unused = ^{DM_addr[N-1:ADDR_W+3], DM_addr[2:0]};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (DM_writeEnable) begin
            r_mem[w_idx] <= DM_writeData;
        end
    end

    assign DM_readData = DM_readEnable ? r_mem[w_idx] : '0;

    // Forward a write landing on the same edge so the latched beat matches memory.
    assign w_seq_rd_data = (DM_writeEnable && (w_idx == w_seq_rd_idx)) ? DM_writeData
                                                                        : r_mem[w_seq_rd_idx];

    dump_sequencer #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_dump_sequencer (
        .clk          (CLOCK_50),
        .rst          (reset),
        .i_dump       (dump),
        .i_dump_ready (dump_ready),
        .i_rd_data    (w_seq_rd_data),
        .o_rd_idx     (w_seq_rd_idx),
        .o_dump_valid (dump_valid),
        .o_dump_index (dump_index),
        .o_dump_data  (dump_data),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done)
    );
endmodule
`default_nettype wire
